image_serializer: RTL

IMAGE_SERIALIZER -- requirements
Module: image_serializer

---
 rtl/image_serializer.sv | 100 ++++++++++
 1 files changed

// File: rtl/image_serializer.sv
// Captures a parallel frame on start and streams it out in raster order over a
// valid/ready handshake, with start-of-frame, end-of-line and end-of-frame markers.
module image_serializer #(
    parameter int WIDTH_P  = 10,
    parameter int HEIGHT_P = 10
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [7:0] image_i [WIDTH_P-1:0][HEIGHT_P-1:0],
    input  logic       start_i,
    input  logic       ready_i,
    output logic       busy_o,
    output logic [7:0] pixel_o,
    output logic       valid_o,
    output logic       sof_o,
    output logic       eol_o,
    output logic       eof_o,
    output logic       done_o
);

    localparam int XW = $clog2(WIDTH_P);
    localparam int YW = $clog2(HEIGHT_P);
    localparam logic [XW-1:0] X_LAST = XW'(WIDTH_P - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT_P - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [7:0]    frame_q [WIDTH_P-1:0][HEIGHT_P-1:0];
    logic          capture;

    assign capture = (state_q == IDLE) && start_i && !reset_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    // The frame store has no reset; it is only ever read after a fresh capture.
    always_ff @(posedge clk_i) begin
        if (capture) begin
            frame_q <= image_i;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = STREAM;
                    x_d     = '0;
                    y_d     = '0;
                end
            end
            STREAM: begin
                if (ready_i) begin
                    if (x_q != X_LAST) begin
                        x_d = x_q + XW'(1);
                    end else if (y_q != Y_LAST) begin
                        x_d = '0;
                        y_d = y_q + YW'(1);
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy_o  = (state_q != IDLE);
    assign valid_o = (state_q == STREAM);
    assign done_o  = (state_q == DONE);
    assign pixel_o = valid_o ? frame_q[x_q][y_q] : 8'h00;
    assign sof_o   = valid_o && (x_q == '0) && (y_q == '0);
    assign eol_o   = valid_o && (x_q == X_LAST);
    assign eof_o   = valid_o && (x_q == X_LAST) && (y_q == Y_LAST);

endmodule
